// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared key codes, matrix geometry and debounce FSM states
package keypad_scanner_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 3;

   typedef logic [3:0] key_code_t;

   localparam key_code_t KEY_STAR = 4'hA;
   localparam key_code_t KEY_HASH = 4'hB;
   localparam key_code_t KEY_NONE = 4'hF;

   typedef enum logic [1:0] {
      ST_RELEASED    = 2'd0,
      ST_DEB_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_DEB_RELEASE = 2'd3
   } deb_state_t;

   // Rows 0..2 carry digits 1..9 in reading order; row 3 is * 0 #.
   function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
      key_code_t code;
      if (row == 2'd3) begin
         code = (col == 2'd0) ? KEY_STAR : ((col == 2'd1) ? 4'h0 : KEY_HASH);
      end else begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - debounced keypad bus towards the microwave control block
interface keypad_scanner_if;
   logic [9:0] keypad;
   logic       star_key;
   logic       hash_key;
   logic       key_strobe;

   modport master (output keypad, star_key, hash_key, key_strobe);
   modport slave  (input  keypad, star_key, hash_key, key_strobe);
endinterface

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - frame-rate debounce FSM turning raw frame codes into a stable key
module keypad_debouncer
   import keypad_scanner_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      frame_valid,
   input  key_code_t frame_code,
   output key_code_t stable_code,
   output logic      strobe
);

   localparam int            CW       = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
   localparam bit            ONE_SHOT = (DEBOUNCE_SCANS == 1);

   deb_state_t    state, state_nxt;
   key_code_t     cand, cand_nxt;
   key_code_t     stable, stable_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          strobe_q, strobe_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RELEASED;
         cand     <= KEY_NONE;
         stable   <= KEY_NONE;
         cnt      <= '0;
         strobe_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         cand     <= cand_nxt;
         stable   <= stable_nxt;
         cnt      <= cnt_nxt;
         strobe_q <= strobe_nxt;
      end
   end

   // cnt only increments below CNT_LAST, so it saturates instead of wrapping.
   always_comb begin
      state_nxt  = state;
      cand_nxt   = cand;
      stable_nxt = stable;
      cnt_nxt    = cnt;
      strobe_nxt = 1'b0;
      if (frame_valid) begin
         unique case (state)
            ST_RELEASED: begin
               if (frame_code != KEY_NONE) begin
                  cand_nxt = frame_code;
                  cnt_nxt  = CW'(1);
                  if (ONE_SHOT) begin
                     state_nxt  = ST_PRESSED;
                     stable_nxt = frame_code;
                     strobe_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_DEB_PRESS;
                  end
               end
            end
            ST_DEB_PRESS: begin
               if (frame_code == cand) begin
                  if (cnt >= CNT_LAST) begin
                     state_nxt  = ST_PRESSED;
                     stable_nxt = cand;
                     strobe_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end else if (frame_code == KEY_NONE) begin
                  state_nxt = ST_RELEASED;
               end else begin
                  cand_nxt = frame_code;
                  cnt_nxt  = CW'(1);
               end
            end
            ST_PRESSED: begin
               if (frame_code != stable) begin
                  cand_nxt = frame_code;
                  cnt_nxt  = CW'(1);
                  if (ONE_SHOT) begin
                     stable_nxt = frame_code;
                     state_nxt  = (frame_code == KEY_NONE) ? ST_RELEASED : ST_PRESSED;
                     strobe_nxt = (frame_code != KEY_NONE);
                  end else begin
                     state_nxt = ST_DEB_RELEASE;
                  end
               end
            end
            ST_DEB_RELEASE: begin
               if (frame_code == stable) begin
                  state_nxt = ST_PRESSED;
               end else if (frame_code == cand) begin
                  if (cnt >= CNT_LAST) begin
                     stable_nxt = cand;
                     state_nxt  = (cand == KEY_NONE) ? ST_RELEASED : ST_PRESSED;
                     strobe_nxt = (cand != KEY_NONE);
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end else begin
                  cand_nxt = frame_code;
                  cnt_nxt  = CW'(1);
               end
            end
         endcase
      end
   end

   always_comb begin
      stable_code = stable;
      strobe      = strobe_q;
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix row scan, frame assembly and debounced keypad bus output
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [COLS-1:0]          col_n,
   output logic [ROWS-1:0]          row_n,
   keypad_scanner_if.master         kp
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [COLS-1:0] col_meta, col_sync;
   logic [DW-1:0]   dwell;
   logic [1:0]      row_idx;
   logic [1:0]      acc_hits, row_hits, tot_hits;
   logic [2:0]      hit_sum;
   key_code_t       acc_code, row_code, tot_code;
   logic            frame_valid;
   key_code_t       frame_code;
   key_code_t       stable_code;
   logic            deb_strobe;
   logic            dwell_last;

   assign dwell_last = (dwell == DW'(SCAN_DIV - 1));
   assign row_n      = ~(4'b0001 << row_idx);

   // Hit count saturates at 2: anything beyond one key is rejected the same way.
   always_comb begin
      row_hits = 2'd0;
      row_code = KEY_NONE;
      for (int c = 0; c < COLS; c++) begin
         if (!col_sync[c]) begin
            row_hits = row_hits + 2'd1;
            row_code = key_map(row_idx, 2'(c));
         end
      end
      hit_sum  = {1'b0, acc_hits} + {1'b0, row_hits};
      tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      tot_code = (acc_hits != 2'd0) ? acc_code : row_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta    <= 3'b111;
         col_sync    <= 3'b111;
         dwell       <= '0;
         row_idx     <= 2'd0;
         acc_hits    <= 2'd0;
         acc_code    <= KEY_NONE;
         frame_valid <= 1'b0;
         frame_code  <= KEY_NONE;
      end else begin
         col_meta    <= col_n;
         col_sync    <= col_meta;
         frame_valid <= 1'b0;
         if (dwell_last) begin
            dwell   <= '0;
            row_idx <= row_idx + 2'd1;
            if (row_idx == 2'd3) begin
               frame_valid <= 1'b1;
               frame_code  <= (tot_hits == 2'd1) ? tot_code : KEY_NONE;
               acc_hits    <= 2'd0;
               acc_code    <= KEY_NONE;
            end else begin
               acc_hits <= tot_hits;
               acc_code <= tot_code;
            end
         end else begin
            dwell <= dwell + DW'(1);
         end
      end
   end

   keypad_debouncer #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debouncer (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_code  (frame_code),
      .stable_code (stable_code),
      .strobe      (deb_strobe)
   );

   always_comb begin
      kp.keypad     = (stable_code <= 4'd9) ? (10'd1 << stable_code) : 10'd0;
      kp.star_key   = (stable_code == KEY_STAR);
      kp.hash_key   = (stable_code == KEY_HASH);
      kp.key_strobe = deb_strobe;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a behavioural key matrix
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic [2:0]  col_n;
   logic [3:0]  row_n;
   logic [11:0] pressed;

   int n_assert;
   int n_fail;
   int strobe_cnt;
   int multi_cnt;

   keypad_scanner_if kp ();

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .col_n (col_n),
      .row_n (row_n),
      .kp    (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key index r*3+c pulls column c low while row r is driven.
   always_comb begin
      col_n = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (!row_n[r] && pressed[r*3+c]) col_n[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (kp.key_strobe) strobe_cnt++;
         if ($countones({kp.keypad, kp.star_key, kp.hash_key}) > 1) multi_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick(1);
         if (kp.key_strobe) seen = 1'b1;
      end
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         tick(1);
         if (kp.keypad == 10'd0 && !kp.star_key && !kp.hash_key) ok = 1'b1;
      end
   endtask

   initial begin
      bit seen;
      int s0;
      n_assert   = 0;
      n_fail     = 0;
      strobe_cnt = 0;
      multi_cnt  = 0;
      pressed    = '0;
      rst        = 1'b1;

      tick(2);
      chk("rst_row_n", 32'(row_n), 32'h0000000e);
      chk("rst_keypad", 32'(kp.keypad), 32'h0);
      chk("rst_star", 32'(kp.star_key), 32'h0);
      chk("rst_hash", 32'(kp.hash_key), 32'h0);
      chk("rst_strobe", 32'(kp.key_strobe), 32'h0);
      rst = 1'b0;

      tick(4); chk("rot_1", 32'(row_n), 32'hd);
      tick(4); chk("rot_2", 32'(row_n), 32'hb);
      tick(4); chk("rot_3", 32'(row_n), 32'h7);
      tick(4); chk("rot_0", 32'(row_n), 32'he);

      pressed[4] = 1'b1;
      s0 = strobe_cnt;
      wait_strobe(51, seen);
      chk("press5_strobe", 32'(seen), 32'h1);
      chk("press5_keypad", 32'(kp.keypad), 32'h020);
      tick(1);
      chk("press5_strobe_one_cycle", 32'(kp.key_strobe), 32'h0);
      tick(64);
      chk("press5_held", 32'(kp.keypad), 32'h020);
      chk("press5_no_restrobe", 32'(strobe_cnt - s0), 32'h1);

      pressed[4] = 1'b0;
      s0 = strobe_cnt;
      wait_idle(51, seen);
      chk("release5_idle", 32'(seen), 32'h1);
      chk("release5_no_strobe", 32'(strobe_cnt - s0), 32'h0);

      for (int i = 0; i < 8; i++) begin
         pressed[4] = ~pressed[4];
         tick(16);
      end
      pressed[4] = 1'b0;
      tick(40);
      chk("bounce_keypad", 32'(kp.keypad), 32'h0);
      chk("bounce_no_strobe", 32'(strobe_cnt - s0), 32'h0);

      pressed[9] = 1'b1;
      wait_strobe(51, seen);
      chk("star_strobe", 32'(seen), 32'h1);
      chk("star_key", 32'(kp.star_key), 32'h1);
      chk("star_no_hash", 32'(kp.hash_key), 32'h0);
      chk("star_no_digit", 32'(kp.keypad), 32'h0);

      pressed[9]  = 1'b0;
      pressed[11] = 1'b1;
      wait_strobe(51, seen);
      chk("hash_strobe", 32'(seen), 32'h1);
      chk("hash_key", 32'(kp.hash_key), 32'h1);
      chk("hash_no_star", 32'(kp.star_key), 32'h0);

      pressed = '0;
      wait_idle(51, seen);
      chk("hash_release_idle", 32'(seen), 32'h1);

      pressed[0] = 1'b1;
      pressed[8] = 1'b1;
      s0 = strobe_cnt;
      tick(80);
      chk("multi_keypad", 32'(kp.keypad), 32'h0);
      chk("multi_no_strobe", 32'(strobe_cnt - s0), 32'h0);
      pressed[8] = 1'b0;
      wait_strobe(51, seen);
      chk("drop9_strobe", 32'(seen), 32'h1);
      chk("drop9_keypad", 32'(kp.keypad), 32'h002);

      pressed = '0;
      wait_idle(51, seen);
      chk("key1_release_idle", 32'(seen), 32'h1);

      pressed[10] = 1'b1;
      wait_strobe(51, seen);
      chk("key0_strobe", 32'(seen), 32'h1);
      chk("key0_keypad", 32'(kp.keypad), 32'h001);
      tick(20);
      rst = 1'b1;
      tick(1);
      chk("midrst_keypad", 32'(kp.keypad), 32'h0);
      chk("midrst_row_n", 32'(row_n), 32'he);
      chk("midrst_strobe", 32'(kp.key_strobe), 32'h0);
      rst = 1'b0;
      wait_strobe(51, seen);
      chk("key0_restrobe", 32'(seen), 32'h1);
      chk("key0_rekeypad", 32'(kp.keypad), 32'h001);

      tick(4);
      chk("never_two_outputs", 32'(multi_cnt), 32'h0);
      chk("total_strobes", 32'(strobe_cnt), 32'h6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
